// File: rtl/sr_bist_pkg.sv
// rtl/sr_bist_pkg.sv - shared types, constants and step table for the SR latch BIST
package sr_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      FINISH
   } state_t;

   typedef struct packed {
      logic e;
      logic s;
      logic r;
      logic exp_q;
   } step_t;

   localparam int SETTLE_MIN = 3;
   localparam logic [2:0] LAST_STEP = 3'd7;

   // S and R are never both high in any entry.
   function automatic step_t step_at(input logic [2:0] idx);
      step_t v;
      case (idx)
         3'd0:    v = 4'b1101;
         3'd1:    v = 4'b1001;
         3'd2:    v = 4'b0011;
         3'd3:    v = 4'b1010;
         3'd4:    v = 4'b0100;
         3'd5:    v = 4'b1101;
         3'd6:    v = 4'b0001;
         default: v = 4'b1010;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/sr_latch_bist_if.sv
// rtl/sr_latch_bist_if.sv - drive/sense connection between the BIST and the gated SR latch
interface sr_latch_bist_if;
   logic s_out;
   logic r_out;
   logic e_out;
   logic q_in;
   logic q_bar_in;

   modport master (
      output s_out,
      output r_out,
      output e_out,
      input  q_in,
      input  q_bar_in
   );

   modport slave (
      input  s_out,
      input  r_out,
      input  e_out,
      output q_in,
      output q_bar_in
   );
endinterface

// File: rtl/sr_latch_bist_sync2.sv
// rtl/sr_latch_bist_sync2.sv - generic 1-bit two-flop synchronizer
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/sr_latch_bist.sv
// rtl/sr_latch_bist.sv - BIST controller applying the eight-step sequence to a gated SR latch
module sr_latch_bist
   import sr_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   sr_latch_bist_if.master lat,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [2:0]      fail_step
);
   // Values below the synchronizer depth cannot observe the response, so clamp.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN : SETTLE_CYCLES;
   localparam int CW = $clog2(SETTLE_EFF);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_EFF - 1);

   state_t          state_q, state_d;
   logic [2:0]      step_q, step_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            s_q, s_d, r_q, r_d, e_q, e_d;
   logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [2:0]      fail_q, fail_d;
   logic            q_sync, qb_sync;
   step_t           cur;

   sync2 u_sync_q  (.clk(clk), .rst_n(rst_n), .d(lat.q_in),     .q(q_sync));
   sync2 u_sync_qb (.clk(clk), .rst_n(rst_n), .d(lat.q_bar_in), .q(qb_sync));

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      r_d     = r_q;
      e_d     = e_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      fail_d  = fail_q;
      cur     = step_at(step_q);
      case (state_q)
         IDLE: begin
            s_d = 1'b0;
            r_d = 1'b0;
            e_d = 1'b0;
            if (start) begin
               state_d = DRIVE;
               step_d  = 3'd0;
               pass_d  = 1'b0;
               fail_d  = 3'd0;
            end
         end
         DRIVE: begin
            e_d     = cur.e;
            s_d     = cur.s;
            r_d     = cur.r;
            cnt_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = CHECK;
         end
         CHECK: begin
            // Q == Q_bar is illegal regardless of the expected value.
            if (q_sync != cur.exp_q || q_sync == qb_sync) begin
               state_d = FINISH;
               pass_d  = 1'b0;
               fail_d  = step_q;
            end else if (step_q == LAST_STEP) begin
               state_d = FINISH;
               pass_d  = 1'b1;
               fail_d  = 3'd0;
            end else begin
               step_d  = step_q + 3'd1;
               state_d = DRIVE;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            s_d     = 1'b0;
            r_d     = 1'b0;
            e_d     = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= 3'd0;
         cnt_q   <= '0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         r_q     <= r_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   assign lat.s_out = s_q;
   assign lat.r_out = r_q;
   assign lat.e_out = e_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_step = fail_q;
endmodule

// File: tb/tb_sr_latch_bist.sv
// tb/tb_sr_latch_bist.sv - scoreboard bench for sr_latch_bist with faulty latch models
module tb_sr_latch_bist;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, pass;
   logic [2:0] fail_step;

   sr_latch_bist_if lat ();

   sr_latch_bist #(.SETTLE_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .lat(lat),
      .busy(busy), .done(done), .pass(pass), .fail_step(fail_step)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pass;
      logic [2:0] fail;
      int         lat;
      int         nsteps;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   done_cnt = 0;
   int   drv_idx = 0;
   int   mode = 0;
   logic lq = 1'b0;
   logic [2:0] prev = 3'b000;
   logic [2:0] tbl [8] = '{3'b110, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b000, 3'b101};

   // mode 0 good latch, 1 Q stuck 0, 2 ignores E, 3 Q_bar tied to Q
   always @(lat.s_out or lat.r_out or lat.e_out or mode) begin
      if (lat.e_out || mode == 2) begin
         if (lat.s_out) lq = 1'b1;
         else if (lat.r_out) lq = 1'b0;
      end
   end
   assign lat.q_in     = (mode == 1) ? 1'b0 : lq;
   assign lat.q_bar_in = (mode == 3) ? lat.q_in : ~lat.q_in;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [2:0] cur;
      exp_t e;
      cur = {lat.e_out, lat.s_out, lat.r_out};
      if (!rst_n) begin
         prev = 3'b000;
         drv_idx = 0;
      end else begin
         checks++;
         if (lat.s_out && lat.r_out) begin
            errors++;
            $display("FAIL s_and_r: got s=%0b r=%0b want not both 1", lat.s_out, lat.r_out);
         end
         if (cur != prev) begin
            if (!done) begin
               checks++;
               if (drv_idx > 7) begin
                  errors++;
                  $display("FAIL extra_step: got esr=%b at index %0d want no further step", cur, drv_idx);
               end else if (cur != tbl[drv_idx]) begin
                  errors++;
                  $display("FAIL step_vec%0d: got esr=%b want %b", drv_idx, cur, tbl[drv_idx]);
               end
               drv_idx++;
            end
            prev = cur;
         end
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 want no done");
            end else begin
               e = exp_q.pop_front();
               checks += 5;
               if (pass !== e.pass) begin
                  errors++;
                  $display("FAIL pass: got %0b want %0b", pass, e.pass);
               end
               if (fail_step !== e.fail) begin
                  errors++;
                  $display("FAIL fail_step: got %0d want %0d", fail_step, e.fail);
               end
               if (cyc - start_cyc != e.lat) begin
                  errors++;
                  $display("FAIL latency: got %0d want %0d", cyc - start_cyc, e.lat);
               end
               if (drv_idx != e.nsteps) begin
                  errors++;
                  $display("FAIL steps_driven: got %0d want %0d", drv_idx, e.nsteps);
               end
               if (busy !== 1'b0 || cur !== 3'b000) begin
                  errors++;
                  $display("FAIL idle_at_done: got busy=%0b esr=%b want 0 000", busy, cur);
               end
            end
            drv_idx = 0;
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      start_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input int m, input logic ep, input logic [2:0] ef,
                      input int elat, input int ens, input bit hammer);
      exp_t e;
      int d0;
      mode = m;
      e.pass = ep; e.fail = ef; e.lat = elat; e.nsteps = ens;
      exp_q.push_back(e);
      d0 = done_cnt;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %0b want 1", busy);
      end
      if (hammer) begin
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = (i % 3 == 0);
         end
         start = 1'b0;
      end
      for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL done_timeout: got no done want done within 300 cycles");
      end
      repeat (6) @(negedge clk);
      checks += 3;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL done_count: got %0d want %0d", done_cnt - d0, 1);
      end
      if (pass !== ep) begin
         errors++;
         $display("FAIL pass_hold: got %0b want %0b", pass, ep);
      end
      if (fail_step !== ef) begin
         errors++;
         $display("FAIL fail_step_hold: got %0d want %0d", fail_step, ef);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({lat.s_out, lat.r_out, lat.e_out, busy, done, pass, fail_step} !== 9'b0) begin
         errors++;
         $display("FAIL %s: got s/r/e=%b%b%b busy=%0b done=%0b pass=%0b fail_step=%0d want all 0",
                  tag, lat.s_out, lat.r_out, lat.e_out, busy, done, pass, fail_step);
      end
   endtask

   initial begin
      int d0;
      #3;
      check_reset_outputs("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(0, 1'b1, 3'd0, 41, 8, 1'b0);
      run(1, 1'b0, 3'd0, 6, 1, 1'b0);
      run(2, 1'b0, 3'd2, 16, 3, 1'b0);
      run(3, 1'b0, 3'd0, 6, 1, 1'b0);

      // Abort during the settle window of step 4.
      mode = 0;
      pulse_start();
      for (int i = 0; i < 100 && drv_idx < 5; i++) @(negedge clk);
      checks++;
      if (drv_idx < 5) begin
         errors++;
         $display("FAIL reach_step4: got %0d steps want 5", drv_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL no_done_after_reset: got %0d dones want 0", done_cnt - d0);
      end
      run(0, 1'b1, 3'd0, 41, 8, 1'b0);

      run(0, 1'b1, 3'd0, 41, 8, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
